// File: rtl/seven_seg_scan_mux.sv
// Purpose : time-multiplexed N-digit seven-segment driver with frame-synchronous
//           double buffering, per-digit blanking, PWM brightness and pin polarity.
// Latency : first slot tick DIV+1 cycles after en is seen high; outputs registered.
// Backpressure: none; free-running scanner, en=0 parks it and idles the outputs.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   en            scan enable (0 = display off, scanner parked)
//   segs_in       packed segment data, digit i at [i*SEG_W +: SEG_W]
//   blank_mask    per-digit blank (1 = all segments off for that digit)
//   duty          on-time per slot in clk cycles (>= DIV+1 means full on)
//   segment       segment drive for the selected digit
//   digit_en      one-hot digit select, all-off when idle
//   sig           1-cycle strobe on every slot change
//   frame_start   1-cycle strobe when digit 0 becomes selected
//   cur_digit     index of the currently selected digit
module seven_seg_scan_mux #(
  parameter int DIV        = 17500,
  parameter int NUM_DIGITS = 2,
  parameter int SEG_W      = 7,
  parameter int ACTIVE_LOW = 0,
  localparam int CBITS     = $clog2(DIV + 1),
  localparam int IW        = $clog2(NUM_DIGITS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_DIGITS*SEG_W-1:0] segs_in,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  input  logic [CBITS-1:0]            duty,
  output logic [SEG_W-1:0]            segment,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        sig,
  output logic                        frame_start,
  output logic [IW-1:0]               cur_digit
);

  localparam logic [CBITS-1:0]      DIV_C    = CBITS'(DIV);
  localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
  // Polarity masks applied as the very last step before the output register.
  localparam logic [SEG_W-1:0]      SEG_POL  = (ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [NUM_DIGITS-1:0] DIG_POL  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CBITS-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [NUM_DIGITS*SEG_W-1:0] shadow_q, shadow_d;
  logic                        sig_q, sig_d;
  logic                        frame_start_q, frame_start_d;
  logic [SEG_W-1:0]            segment_q, segment_d;
  logic [NUM_DIGITS-1:0]       digit_en_q, digit_en_d;

  logic                        on_d;
  logic                        blank_sel;
  logic [SEG_W-1:0]            seg_sel;
  logic [NUM_DIGITS-1:0]       den_raw;

  // Prescaler, digit index and shadow capture.
  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    sig_d         = 1'b0;
    frame_start_d = 1'b0;
    if (!en) begin
      // Park on the last digit so the first tick after re-enable lands on digit 0.
      cnt_d = '0;
      idx_d = LAST_IDX;
    end else if (cnt_q == DIV_C) begin
      cnt_d = '0;
      sig_d = 1'b1;
      if (idx_q == LAST_IDX) begin
        idx_d         = '0;
        shadow_d      = segs_in;
        frame_start_d = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      cnt_d = cnt_q + CBITS'(1);
    end
  end

  // Output decode works on the post-update state so the pins follow the slot
  // in the same cycle the strobe is raised.
  always_comb begin
    on_d      = en && (cnt_d < duty);
    seg_sel   = '0;
    den_raw   = '0;
    blank_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        seg_sel    = shadow_d[i*SEG_W +: SEG_W];
        den_raw[i] = on_d;
        blank_sel  = blank_mask[i];
      end
    end
    segment_d  = ((on_d && !blank_sel) ? seg_sel : '0) ^ SEG_POL;
    digit_en_d = den_raw ^ DIG_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= LAST_IDX;
      shadow_q      <= '0;
      sig_q         <= 1'b0;
      frame_start_q <= 1'b0;
      segment_q     <= SEG_POL;
      digit_en_q    <= DIG_POL;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      sig_q         <= sig_d;
      frame_start_q <= frame_start_d;
      segment_q     <= segment_d;
      digit_en_q    <= digit_en_d;
    end
  end

  assign segment     = segment_q;
  assign digit_en    = digit_en_q;
  assign sig         = sig_q;
  assign frame_start = frame_start_q;
  assign cur_digit   = idx_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
module tb_seven_seg_scan_mux;

  // Instance A: DIV=3, 3 digits, 7 segments, active high.
  localparam int DA = 3, NA = 3, WA = 7;
  // Instance B: DIV=4, 5 digits, 8 segments, active low.
  localparam int DB = 4, NB = 5, WB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          en_a = 1'b0;
  logic [20:0]   segs_a = '0;
  logic [2:0]    blank_a = '0;
  logic [1:0]    duty_a = 2'd3;
  logic [6:0]    seg_a;
  logic [2:0]    den_a;
  logic          sig_a, fs_a;
  logic [1:0]    cur_a;

  logic          en_b = 1'b0;
  logic [39:0]   segs_b = '0;
  logic [4:0]    blank_b = '0;
  logic [2:0]    duty_b = 3'd7;
  logic [7:0]    seg_b;
  logic [4:0]    den_b;
  logic          sig_b, fs_b;
  logic [2:0]    cur_b;

  int checks = 0;
  int failures = 0;

  seven_seg_scan_mux #(.DIV(DA), .NUM_DIGITS(NA), .SEG_W(WA), .ACTIVE_LOW(0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .segs_in(segs_a), .blank_mask(blank_a),
    .duty(duty_a), .segment(seg_a), .digit_en(den_a), .sig(sig_a),
    .frame_start(fs_a), .cur_digit(cur_a));

  seven_seg_scan_mux #(.DIV(DB), .NUM_DIGITS(NB), .SEG_W(WB), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .segs_in(segs_b), .blank_mask(blank_b),
    .duty(duty_b), .segment(seg_b), .digit_en(den_b), .sig(sig_b),
    .frame_start(fs_b), .cur_digit(cur_b));

  // ---------------- reference model ----------------
  // k = number of consecutive enabled clock edges. Everything follows from it:
  // slot phase = k mod (DIV+1), slots elapsed = k div (DIV+1), the digit shown
  // is the last one before any slot has elapsed, otherwise (slots-1) mod N.
  function automatic logic [20:0] model_out(int k, bit en, logic [63:0] sh,
                                            logic [7:0] blank, int duty,
                                            int d, int n, int w, bit al);
    int c, t, ix;
    logic [7:0] seg, den;
    bit s, lit;
    c   = k % (d + 1);
    t   = k / (d + 1);
    ix  = (t == 0) ? n - 1 : (t - 1) % n;
    s   = en && (k > 0) && (c == 0);
    lit = en && (c < duty);
    den = lit ? (8'd1 << ix) : 8'd0;
    seg = (lit && !blank[ix]) ? 8'((sh >> (ix * w)) & ((64'd1 << w) - 1)) : 8'd0;
    if (al) begin
      seg = seg ^ 8'((1 << w) - 1);
      den = den ^ 8'((1 << n) - 1);
    end
    return {seg, den, s, s && (ix == 0), 3'(ix)};
  endfunction

  int          ka, kb;
  bit          ena_m, enb_m;
  logic [63:0] sha, shb;
  logic [7:0]  blka_m, blkb_m;
  int          dutya_m, dutyb_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ka = 0; ena_m = 0; sha = '0; blka_m = '0; dutya_m = 0;
    end else begin
      ena_m = en_a; blka_m = 8'(blank_a); dutya_m = int'(duty_a);
      if (en_a) begin
        ka++;
        // A new frame begins when a slot boundary selects digit 0.
        if (ka % (DA + 1) == 0 && ((ka / (DA + 1)) - 1) % NA == 0) sha = 64'(segs_a);
      end else ka = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb = 0; enb_m = 0; shb = '0; blkb_m = '0; dutyb_m = 0;
    end else begin
      enb_m = en_b; blkb_m = 8'(blank_b); dutyb_m = int'(duty_b);
      if (en_b) begin
        kb++;
        if (kb % (DB + 1) == 0 && ((kb / (DB + 1)) - 1) % NB == 0) shb = 64'(segs_b);
      end else kb = 0;
    end
  end

  logic [20:0] obs_a, exp_a, obs_b, exp_b;
  always_comb begin
    obs_a = {8'(seg_a), 8'(den_a), sig_a, fs_a, 3'(cur_a)};
    obs_b = {8'(seg_b), 8'(den_b), sig_b, fs_b, 3'(cur_b)};
    exp_a = model_out(ka, ena_m, sha, blka_m, dutya_m, DA, NA, WA, 1'b0);
    exp_b = model_out(kb, enb_m, shb, blkb_m, dutyb_m, DB, NB, WB, 1'b1);
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (seg_a !== 7'h00 || den_a !== 3'b000 || sig_a !== 1'b0 || fs_a !== 1'b0 || cur_a !== 2'd2) begin
      failures++;
      $display("FAIL reset_a got seg=%h den=%b sig=%b fs=%b cur=%0d want 00 000 0 0 2",
               seg_a, den_a, sig_a, fs_a, cur_a);
    end
    checks++;
    if (seg_b !== 8'hFF || den_b !== 5'h1F || sig_b !== 1'b0 || fs_b !== 1'b0 || cur_b !== 3'd4) begin
      failures++;
      $display("FAIL reset_b got seg=%h den=%b sig=%b fs=%b cur=%0d want ff 11111 0 0 4",
               seg_b, den_b, sig_b, fs_b, cur_b);
    end
  endtask

  task automatic test_basic_scan();
    segs_a = {7'h06, 7'h5B, 7'h3F};
    duty_a = 2'd3;
    en_a   = 1'b1;
    rst_n  = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_a !== exp_a) begin
        failures++;
        $display("FAIL scan_model edge=%0d got %h want %h", e, obs_a, exp_a);
      end
      if (e == 3) begin
        checks++;
        if (sig_a !== 1'b0) begin
          failures++;
          $display("FAIL scan_no_early_sig got %b want 0", sig_a);
        end
      end
      if (e == 4 || e == 16) begin
        checks++;
        if ({sig_a, fs_a, den_a, seg_a} !== {1'b1, 1'b1, 3'b001, 7'h3F}) begin
          failures++;
          $display("FAIL scan_digit0 edge=%0d got sig=%b fs=%b den=%b seg=%h want 1 1 001 3f",
                   e, sig_a, fs_a, den_a, seg_a);
        end
      end
      if (e == 8) begin
        checks++;
        if ({sig_a, fs_a, den_a, seg_a} !== {1'b1, 1'b0, 3'b010, 7'h5B}) begin
          failures++;
          $display("FAIL scan_digit1 got sig=%b fs=%b den=%b seg=%h want 1 0 010 5b",
                   sig_a, fs_a, den_a, seg_a);
        end
      end
      if (e == 12) begin
        checks++;
        if ({sig_a, fs_a, den_a, seg_a} !== {1'b1, 1'b0, 3'b100, 7'h06}) begin
          failures++;
          $display("FAIL scan_digit2 got sig=%b fs=%b den=%b seg=%h want 1 0 100 06",
                   sig_a, fs_a, den_a, seg_a);
        end
      end
    end
  endtask

  task automatic test_coherence();
    logic [20:0] nv;
    nv = {7'h79, 14'($urandom)};
    for (int r = 1; r <= 16; r++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_a !== exp_a) begin
        failures++;
        $display("FAIL coh_model r=%0d got %h want %h", r, obs_a, exp_a);
      end
      if (r == 8) begin
        checks++;
        if (seg_a !== 7'h06 || den_a !== 3'b100) begin
          failures++;
          $display("FAIL coh_old_data got den=%b seg=%h want 100 06", den_a, seg_a);
        end
      end
      if (r == 12) begin
        checks++;
        if (seg_a !== nv[6:0] || fs_a !== 1'b1) begin
          failures++;
          $display("FAIL coh_new_frame got fs=%b seg=%h want 1 %h", fs_a, seg_a, nv[6:0]);
        end
      end
      if (r == 5) segs_a = nv;   // digit 1 is on the pins now
    end
  endtask

  task automatic test_blank();
    int seen;
    seen = 0;
    blank_a = 3'b010;
    for (int r = 0; r < 24; r++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_a !== exp_a) begin
        failures++;
        $display("FAIL blank_model r=%0d got %h want %h", r, obs_a, exp_a);
      end
      if (den_a == 3'b010) begin
        seen++;
        checks++;
        if (seg_a !== 7'h00) begin
          failures++;
          $display("FAIL blank_seg got %h want 00", seg_a);
        end
      end
      if (r % 5 == 4) segs_a = 21'($urandom);
    end
    checks++;
    if (seen == 0) begin
      failures++;
      $display("FAIL blank_slot_seen got 0 want >0");
    end
    blank_a = 3'b000;
  endtask

  task automatic test_duty();
    int lit, sigs;
    lit = 0;
    duty_a = 2'd2;
    for (int r = 0; r < 24; r++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_a !== exp_a) begin
        failures++;
        $display("FAIL duty2_model r=%0d got %h want %h", r, obs_a, exp_a);
      end
      if (den_a != 3'b000) lit++;
    end
    checks++;
    if (lit != 12) begin
      failures++;
      $display("FAIL duty2_lit_cycles got %0d want 12", lit);
    end
    duty_a = 2'd0;
    lit = 0; sigs = 0;
    for (int r = 0; r < 24; r++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_a !== exp_a) begin
        failures++;
        $display("FAIL duty0_model r=%0d got %h want %h", r, obs_a, exp_a);
      end
      if (den_a != 3'b000 || seg_a != 7'h00) lit++;
      if (sig_a) sigs++;
    end
    checks++;
    if (lit != 0 || sigs != 6) begin
      failures++;
      $display("FAIL duty0_dark got lit=%0d sigs=%0d want lit=0 sigs=6", lit, sigs);
    end
    for (int r = 0; r < 40; r++) begin
      duty_a = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      checks++;
      if (obs_a !== exp_a) begin
        failures++;
        $display("FAIL duty_rand_model r=%0d got %h want %h", r, obs_a, exp_a);
      end
    end
    duty_a = 2'd3;
  endtask

  task automatic test_enable_reset();
    repeat (2) @(posedge clk);
    #1;
    en_a = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (den_a !== 3'b000 || seg_a !== 7'h00 || sig_a !== 1'b0 || cur_a !== 2'd2) begin
      failures++;
      $display("FAIL en_off_idle got den=%b seg=%h sig=%b cur=%0d want 000 00 0 2",
               den_a, seg_a, sig_a, cur_a);
    end
    en_a = 1'b1;
    segs_a = 21'($urandom);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_a !== exp_a) begin
        failures++;
        $display("FAIL reen_model e=%0d got %h want %h", e, obs_a, exp_a);
      end
      if (e == 4) begin
        checks++;
        if (fs_a !== 1'b1 || den_a !== 3'b001 || seg_a !== segs_a[6:0]) begin
          failures++;
          $display("FAIL reen_frame got fs=%b den=%b seg=%h want 1 001 %h",
                   fs_a, den_a, seg_a, segs_a[6:0]);
        end
      end
    end
    for (int r = 0; r < 80; r++) begin
      en_a    = ($urandom_range(0, 7) != 0);
      blank_a = 3'($urandom);
      duty_a  = 2'($urandom);
      if (r % 7 == 0) segs_a = 21'($urandom);
      @(posedge clk); #1;
      checks++;
      if (obs_a !== exp_a) begin
        failures++;
        $display("FAIL en_rand_model r=%0d got %h want %h", r, obs_a, exp_a);
      end
    end
    en_a = 1'b1; blank_a = '0; duty_a = 2'd3;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg_a !== 7'h00 || den_a !== 3'b000 || sig_a !== 1'b0 || fs_a !== 1'b0 || cur_a !== 2'd2) begin
      failures++;
      $display("FAIL async_reset got seg=%h den=%b sig=%b fs=%b cur=%0d want 00 000 0 0 2",
               seg_a, den_a, sig_a, fs_a, cur_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_a !== exp_a) begin
        failures++;
        $display("FAIL post_reset_model e=%0d got %h want %h", e, obs_a, exp_a);
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_active_low_wide();
    int since_sig, wraps;
    logic [2:0] prev_cur;
    since_sig = 0; wraps = 0;
    prev_cur = cur_b;
    segs_b = {$urandom, $urandom};
    duty_b = 3'd7;
    en_b = 1'b1;
    for (int r = 0; r < 600; r++) begin
      if (r % 37 == 36) blank_b = 5'($urandom);
      if (r % 23 == 22) duty_b = 3'($urandom);
      if (r % 11 == 10) segs_b = {$urandom, $urandom};
      if (r % 150 == 149) en_b = 1'b0;
      else en_b = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (obs_b !== exp_b) begin
        failures++;
        $display("FAIL al_model r=%0d got %h want %h", r, obs_b, exp_b);
      end
      if ($countones(~den_b) > 1) begin
        failures++;
        $display("FAIL al_onehot got den=%b want at most one low bit", den_b);
      end
      if (prev_cur == 3'd4 && cur_b == 3'd0) wraps++;
      prev_cur = cur_b;
      if (sig_b || !en_b) since_sig = 0;
      else since_sig++;
      if (since_sig > DB + 1) begin
        failures++;
        $display("FAIL al_liveness gap=%0d want <=%0d", since_sig, DB + 1);
        since_sig = 0;
      end
    end
    checks++;
    if (wraps < 5) begin
      failures++;
      $display("FAIL al_wrap got %0d wraps want >=5", wraps);
    end
    en_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_coherence();
    test_blank();
    test_duty();
    test_enable_reset();
    test_active_low_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
